hd_downscale_avg: RTL and testbench
===================================

Name: hd_downscale_avg

Overview:
- Parametrised 2^SHIFT x 2^SHIFT spatial decimator for the HD camera pixel stream, clocked on pclk.
- Produces a reduced-resolution RGB565 and 8-bit grey stream, plus a linear write address, for the small frame buffer that feeds the stereo-matching stage.
- Two modes, selected per frame:
  - point sample: takes the top-left pixel of each block;
  - box average: takes the mean of all pixels in each block.

Parameters:
- SHIFT, 2, log2 of decimation factor per axis (1..3).
- OUT_W, 160, output frame width in pixels.
- OUT_H, 120, output frame height in pixels.
- ADDR_W, 15, width of Addr_o; must satisfy 2^ADDR_W >= OUT_W*OUT_H.

Ports:
- pclk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- de  in  1  input pixel valid.
- mode  in  1  0 = point sample, 1 = box average; latched per frame.
- RGB565  in  16  input pixel {R5,G6,B5}.
- H_cnt  in  12  input column index.
- V_cnt  in  11  input row index.
- o_valid  out  1  one-cycle strobe: output pixel valid.
- RGB565_o  out  16  decimated pixel.
- GREY_o  out  8  grey value of RGB565_o.
- Addr_o  out  ADDR_W  buffer address.
- frame_done  out  1  one-cycle pulse coincident with the final o_valid of a frame.

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is pclk. On reset all outputs go to 0, mode_q = 0, and horizontal accumulators clear. The column accumulator array is not reset (see stale-data rule below).
- Block coordinates: bx = H_cnt >> SHIFT, by = V_cnt >> SHIFT.
  - A pixel is in-window when bx < OUT_W and by < OUT_H.
  - Pixels with de = 0 or out of window: ignored. No accumulation, no strobe.
- Mode latch: mode_q <= mode on the pixel with de = 1, H_cnt = 0, V_cnt = 0. Mode changes mid-frame take effect at the next frame start.
- Point mode (mode_q = 0):
  - Emits on the in-window pixel whose H_cnt and V_cnt low SHIFT bits are both 0.
  - RGB565_o = RGB565; latency 1 cycle.
- Box mode (mode_q = 1):
  - Horizontal accumulator per channel: R, B 5+SHIFT bits; G 6+SHIFT bits.
    - Loads on H low bits == 0 and adds on the other pixels of the block.
  - Column array: OUT_W entries of {R, G, B} sums; R, B 5+2*SHIFT bits, G 6+2*SHIFT bits. Asynchronous-read register array.
    - At H low bits == all-ones the horizontal sum (including the current pixel) is written to entry bx.
    - If V low bits == 0 the entry is overwritten; otherwise it is added. No stale data crosses blocks, so no clear is needed.
  - Emit: at the pixel with H and V low bits both all-ones.
    - Each channel = (column sum + row sum) >> (2*SHIFT), truncated.
    - Latency 1 cycle after that pixel.
  - Missing pixels (de = 0 inside a block) are omitted from the sum; the average is not renormalised.
- Grey, computed from the emitted RGB: GREY_o = 2*R + 2*G + B, 8 bits. Maximum value 219, so no overflow.
- Address: Addr_o = OUT_W*by + bx, registered with the data.
- Hold: RGB565_o, GREY_o and Addr_o hold their values between strobes. o_valid is low except on emit cycles.
- frame_done: asserted with the o_valid for bx = OUT_W-1, by = OUT_H-1.
- Reset mid-frame: outputs return to 0. Processing resumes correctly from the next block row via the overwrite rule; partial blocks in the current block row are undefined and need not be checked.

Decomposition:
- Shared package hd_scale_pkg: RGB565 field slice constants (R_MSB etc.) and the grey-weight function. The same function is used by any future grey path.
- One natural sub-module, hd_col_accum: the OUT_W-entry column array with its overwrite/add write port and asynchronous read. It is parametrised on OUT_W and the sum widths.

Test Plan (SHIFT=2, OUT_W=160, OUT_H=120 unless stated):
1. Reset test: assert rst_n low mid-stream -> all outputs 0 within the same cycle; no o_valid until a new qualifying pixel arrives.
2. Point mode sampling: mode=0, pixel H=8, V=4, RGB565=16'hF800 -> next cycle o_valid=1, Addr_o=162, RGB565_o=16'hF800, GREY_o=62. Pixel H=9, V=4 -> no strobe.
3. Box mode averaging: mode=1, block (0,0), R alternating 31/0 across all 16 pixels, G=63, B=0 -> strobe one cycle after H=3, V=3 with RGB565_o=16'h7FE0 (R=15 truncated, G=63), GREY_o=156, Addr_o=0. A second frame with all-zero input gives 16'h0000, proving the overwrite rule.
4. Window clip: H_cnt 640..1919 and V_cnt 480..1079 with de=1 -> no o_valid and no change to held outputs.
5. Mode latch: toggle mode at V=100 -> behaviour unchanged until the next H=0, V=0 pixel, then switches.
6. End of frame, and SHIFT=1 build: full frame, 4 px and 2 px variants. Last strobe has Addr_o=19199 with frame_done=1, and exactly 19200 strobes per frame. With SHIFT=1, OUT_W=320, OUT_H=240 there are 76800 strobes and the final Addr_o is 76799 (ADDR_W=17).

Source files
------------

// File: rtl/hd_scale_pkg.sv
// rtl/hd_scale_pkg.sv - RGB565 field slices and grey weighting shared by the scaler paths
package hd_scale_pkg;

  localparam int R_MSB = 15;
  localparam int R_LSB = 11;
  localparam int G_MSB = 10;
  localparam int G_LSB = 5;
  localparam int B_MSB = 4;
  localparam int B_LSB = 0;
  localparam int R_W   = R_MSB - R_LSB + 1;
  localparam int G_W   = G_MSB - G_LSB + 1;
  localparam int B_W   = B_MSB - B_LSB + 1;

  // 2R + 2G + B peaks at 219, so 8 bits never wrap.
  function automatic logic [7:0] grey565(input logic [15:0] pix);
    return {2'b00, pix[R_MSB:R_LSB], 1'b0}
         + {1'b0, pix[G_MSB:G_LSB], 1'b0}
         + {3'b000, pix[B_MSB:B_LSB]};
  endfunction

endpackage

// File: rtl/hd_col_accum.sv
// rtl/hd_col_accum.sv - per-output-column {R,G,B} partial block sums, overwrite/add write, async read
module hd_col_accum #(
  parameter int OUT_W = 160,
  parameter int RW    = 9,
  parameter int GW    = 10,
  parameter int IDX_W = $clog2(OUT_W)
) (
  input  logic             pclk,
  input  logic             we,
  input  logic             add,
  input  logic [IDX_W-1:0] idx,
  input  logic [RW-1:0]    wr_r,
  input  logic [GW-1:0]    wr_g,
  input  logic [RW-1:0]    wr_b,
  output logic [RW-1:0]    rd_r,
  output logic [GW-1:0]    rd_g,
  output logic [RW-1:0]    rd_b
);

  // No reset: the first row of every block overwrites its entry.
  logic [RW-1:0] mem_r [OUT_W];
  logic [GW-1:0] mem_g [OUT_W];
  logic [RW-1:0] mem_b [OUT_W];

  assign rd_r = mem_r[idx];
  assign rd_g = mem_g[idx];
  assign rd_b = mem_b[idx];

  always_ff @(posedge pclk) begin
    if (we) begin
      mem_r[idx] <= add ? mem_r[idx] + wr_r : wr_r;
      mem_g[idx] <= add ? mem_g[idx] + wr_g : wr_g;
      mem_b[idx] <= add ? mem_b[idx] + wr_b : wr_b;
    end
  end

endmodule

// File: rtl/hd_downscale_avg.sv
// rtl/hd_downscale_avg.sv - 2^SHIFT x 2^SHIFT point-sample / box-average pixel decimator
module hd_downscale_avg
  import hd_scale_pkg::*;
#(
  parameter int SHIFT  = 2,
  parameter int OUT_W  = 160,
  parameter int OUT_H  = 120,
  parameter int ADDR_W = 15
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              de,
  input  logic              mode,
  input  logic [15:0]       RGB565,
  input  logic [11:0]       H_cnt,
  input  logic [10:0]       V_cnt,
  output logic              o_valid,
  output logic [15:0]       RGB565_o,
  output logic [7:0]        GREY_o,
  output logic [ADDR_W-1:0] Addr_o,
  output logic              frame_done
);

  localparam int HRW   = R_W + SHIFT;
  localparam int HGW   = G_W + SHIFT;
  localparam int CRW   = R_W + 2 * SHIFT;
  localparam int CGW   = G_W + 2 * SHIFT;
  localparam int IDX_W = $clog2(OUT_W);
  localparam logic [SHIFT-1:0] LO_ONES = {SHIFT{1'b1}};

  logic [11-SHIFT:0] bx;
  logic [10-SHIFT:0] by;
  logic [SHIFT-1:0]  h_lo, v_lo;
  logic              in_win, hit, frame_start, mode_q, mode_eff;
  logic              h_first, h_last, v_first, v_last, emit, last_blk;
  logic [R_W-1:0]    px_r;
  logic [G_W-1:0]    px_g;
  logic [B_W-1:0]    px_b;
  logic [HRW-1:0]    h_acc_r, h_acc_b, hsum_r, hsum_b;
  logic [HGW-1:0]    h_acc_g, hsum_g;
  logic [CRW-1:0]    col_r, col_b, tot_r, tot_b;
  logic [CGW-1:0]    col_g, tot_g;
  logic [15:0]       box_pix, out_pix;

  assign bx   = H_cnt[11:SHIFT];
  assign by   = V_cnt[10:SHIFT];
  assign h_lo = H_cnt[SHIFT-1:0];
  assign v_lo = V_cnt[SHIFT-1:0];

  assign in_win      = (32'(bx) < 32'(OUT_W)) && (32'(by) < 32'(OUT_H));
  assign hit         = de && in_win;
  assign frame_start = de && (H_cnt == 12'd0) && (V_cnt == 11'd0);
  // The frame's first pixel already obeys the newly sampled mode.
  assign mode_eff    = frame_start ? mode : mode_q;

  assign h_first = (h_lo == '0);
  assign h_last  = (h_lo == LO_ONES);
  assign v_first = (v_lo == '0);
  assign v_last  = (v_lo == LO_ONES);

  assign px_r = RGB565[R_MSB:R_LSB];
  assign px_g = RGB565[G_MSB:G_LSB];
  assign px_b = RGB565[B_MSB:B_LSB];

  // Row sum of the current block including this pixel.
  assign hsum_r = (h_first ? HRW'(0) : h_acc_r) + HRW'(px_r);
  assign hsum_g = (h_first ? HGW'(0) : h_acc_g) + HGW'(px_g);
  assign hsum_b = (h_first ? HRW'(0) : h_acc_b) + HRW'(px_b);

  hd_col_accum #(
    .OUT_W (OUT_W),
    .RW    (CRW),
    .GW    (CGW),
    .IDX_W (IDX_W)
  ) u_col_accum (
    .pclk (pclk),
    .we   (hit && h_last),
    .add  (!v_first),
    .idx  (bx[IDX_W-1:0]),
    .wr_r (CRW'(hsum_r)),
    .wr_g (CGW'(hsum_g)),
    .wr_b (CRW'(hsum_b)),
    .rd_r (col_r),
    .rd_g (col_g),
    .rd_b (col_b)
  );

  assign tot_r   = col_r + CRW'(hsum_r);
  assign tot_g   = col_g + CGW'(hsum_g);
  assign tot_b   = col_b + CRW'(hsum_b);
  assign box_pix = {tot_r[CRW-1:2*SHIFT], tot_g[CGW-1:2*SHIFT], tot_b[CRW-1:2*SHIFT]};
  assign out_pix = mode_eff ? box_pix : RGB565;

  assign emit     = hit && (mode_eff ? (h_last && v_last) : (h_first && v_first));
  assign last_blk = (32'(bx) == 32'(OUT_W - 1)) && (32'(by) == 32'(OUT_H - 1));

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= 1'b0;
      h_acc_r    <= '0;
      h_acc_g    <= '0;
      h_acc_b    <= '0;
      o_valid    <= 1'b0;
      frame_done <= 1'b0;
      RGB565_o   <= '0;
      GREY_o     <= '0;
      Addr_o     <= '0;
    end else begin
      if (frame_start) begin
        mode_q <= mode;
      end
      if (hit) begin
        h_acc_r <= h_last ? HRW'(0) : hsum_r;
        h_acc_g <= h_last ? HGW'(0) : hsum_g;
        h_acc_b <= h_last ? HRW'(0) : hsum_b;
      end
      o_valid    <= emit;
      frame_done <= emit && last_blk;
      if (emit) begin
        RGB565_o <= out_pix;
        GREY_o   <= grey565(out_pix);
        Addr_o   <= ADDR_W'(32'(by) * 32'(OUT_W) + 32'(bx));
      end
    end
  end

endmodule

// File: tb/tb_hd_downscale_avg.sv
// tb/tb_hd_downscale_avg.sv - scoreboard bench for hd_downscale_avg, SHIFT=2 160x120 build
module tb_hd_downscale_avg;

  localparam int SHIFT  = 2;
  localparam int OUT_W  = 160;
  localparam int OUT_H  = 120;
  localparam int ADDR_W = 15;

  logic              pclk, rst_n, de, mode;
  logic [15:0]       RGB565;
  logic [11:0]       H_cnt;
  logic [10:0]       V_cnt;
  logic              o_valid, frame_done;
  logic [15:0]       RGB565_o;
  logic [7:0]        GREY_o;
  logic [ADDR_W-1:0] Addr_o;

  hd_downscale_avg #(
    .SHIFT (SHIFT), .OUT_W (OUT_W), .OUT_H (OUT_H), .ADDR_W (ADDR_W)
  ) dut (
    .pclk (pclk), .rst_n (rst_n), .de (de), .mode (mode), .RGB565 (RGB565),
    .H_cnt (H_cnt), .V_cnt (V_cnt), .o_valid (o_valid), .RGB565_o (RGB565_o),
    .GREY_o (GREY_o), .Addr_o (Addr_o), .frame_done (frame_done)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic [15:0] rgb;
    logic [7:0]  grey;
    int          addr;
    bit          fd;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  int   strobes = 0;
  int   fdones = 0;
  int   sr[2], sg[2], sb[2];
  int   st0, fd0;
  logic [15:0] pix;

  function automatic logic [7:0] gmodel(input logic [15:0] p);
    int g;
    g = 2 * int'(p[15:11]) + 2 * int'(p[10:5]) + int'(p[4:0]);
    return g[7:0];
  endfunction

  function automatic exp_t mk(input logic [15:0] rgb, input int addr, input bit fd);
    exp_t e;
    e.rgb  = rgb;
    e.grey = gmodel(rgb);
    e.addr = addr;
    e.fd   = fd;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic px(input bit d, input int h, input int v, input logic [15:0] c);
    de     = d;
    H_cnt  = h[11:0];
    V_cnt  = v[10:0];
    RGB565 = c;
    @(posedge pclk);
    #1;
  endtask

  task automatic idle(input int n);
    de = 1'b0;
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  always @(negedge pclk) begin
    if (rst_n && o_valid) begin
      strobes++;
      if (frame_done) fdones++;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe actual addr=%0d rgb=%h expected no strobe", Addr_o, RGB565_o);
      end else begin
        mon_e = q.pop_front();
        if (RGB565_o !== mon_e.rgb || GREY_o !== mon_e.grey ||
            32'(Addr_o) !== mon_e.addr || frame_done !== mon_e.fd) begin
          fails++;
          $display("FAIL strobe actual rgb=%h grey=%0d addr=%0d fd=%b expected rgb=%h grey=%0d addr=%0d fd=%b",
                   RGB565_o, GREY_o, Addr_o, frame_done, mon_e.rgb, mon_e.grey, mon_e.addr, mon_e.fd);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; de = 1'b0; mode = 1'b0; RGB565 = '0; H_cnt = '0; V_cnt = '0;
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_rgb",   32'(RGB565_o), 0);
    chk("rst_grey",  32'(GREY_o), 0);
    chk("rst_addr",  32'(Addr_o), 0);
    chk("rst_fd",    32'(frame_done), 0);
    rst_n = 1'b1;
    idle(1);

    // Point mode sampling
    mode = 1'b0;
    q.push_back(mk(16'h1234, 0, 0));
    px(1, 0, 0, 16'h1234);
    q.push_back(mk(16'hF800, 162, 0));
    px(1, 8, 4, 16'hF800);
    px(1, 9, 4, 16'hFFFF);
    px(1, 10, 5, 16'hFFFF);
    idle(2);
    chk("pt_rgb",  32'(RGB565_o), 32'h0000_F800);
    chk("pt_grey", 32'(GREY_o), 62);
    chk("pt_addr", 32'(Addr_o), 162);

    // Window clip and de=0 on a sampling position
    px(1, 640, 480, 16'hFFFF);
    px(1, 1919, 1079, 16'hFFFF);
    px(1, 640, 0, 16'hFFFF);
    px(1, 0, 480, 16'hFFFF);
    px(0, 16, 0, 16'hFFFF);
    idle(2);
    chk("clip_rgb",  32'(RGB565_o), 32'h0000_F800);
    chk("clip_grey", 32'(GREY_o), 62);
    chk("clip_addr", 32'(Addr_o), 162);
    chk("clip_valid", 32'(o_valid), 0);

    // Mode change mid-frame stays in point mode
    mode = 1'b1;
    q.push_back(mk(16'h07E0, 4003, 0));
    px(1, 12, 100, 16'h07E0);
    idle(1);

    // Box frame: block 0 alternating R, block 1 ramp with one missing pixel
    for (int b = 0; b < 2; b++) begin
      sr[b] = 0; sg[b] = 0; sb[b] = 0;
    end
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 8; h++) begin
        bit d;
        int b;
        b = h / 4;
        d = !(h == 5 && v == 2);
        if (b == 0) pix = {((h % 2) == 0) ? 5'd31 : 5'd0, 6'd63, 5'd0};
        else        pix = {5'(h + v), 6'(4 * h + v), 5'(31 - h)};
        if (d) begin
          sr[b] += int'(pix[15:11]);
          sg[b] += int'(pix[10:5]);
          sb[b] += int'(pix[4:0]);
        end
        if (v == 3 && h == 3) q.push_back(mk(16'h7FE0, 0, 0));
        if (v == 3 && h == 7) q.push_back(mk({5'(sr[1] / 16), 6'(sg[1] / 16), 5'(sb[1] / 16)}, 1, 0));
        px(d, h, v, pix);
      end
    end
    idle(2);
    chk("box_grey0_then1", 32'(Addr_o), 1);

    // Mode toggle inside a box frame has no effect until next frame
    mode = 1'b0;
    px(1, 8, 100, 16'hFFFF);
    idle(2);
    q.push_back(mk(16'hABCD, 0, 0));
    px(1, 0, 0, 16'hABCD);
    q.push_back(mk(16'h1357, 1, 0));
    px(1, 4, 0, 16'h1357);
    idle(2);

    // Box frame of zeros overwrites column entry 0
    mode = 1'b1;
    for (int v = 0; v < 4; v++) begin
      for (int h = 0; h < 4; h++) begin
        if (v == 3 && h == 3) q.push_back(mk(16'h0000, 0, 0));
        px(1, h, v, 16'h0000);
      end
    end
    idle(2);
    chk("box_zero_rgb", 32'(RGB565_o), 0);

    // Asynchronous reset mid-stream
    mode = 1'b0;
    q.push_back(mk(16'h5555, 0, 0));
    px(1, 0, 0, 16'h5555);
    q.push_back(mk(16'hAAAA, 161, 0));
    px(1, 4, 4, 16'hAAAA);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(o_valid), 0);
    chk("mid_rst_rgb",   32'(RGB565_o), 0);
    chk("mid_rst_grey",  32'(GREY_o), 0);
    chk("mid_rst_addr",  32'(Addr_o), 0);
    chk("mid_rst_fd",    32'(frame_done), 0);
    @(posedge pclk);
    #1;
    rst_n = 1'b1;
    idle(3);
    q.push_back(mk(16'h0F0F, 163, 0));
    px(1, 12, 4, 16'h0F0F);
    idle(2);

    // Full point-mode frame on sampling positions only
    mode = 1'b0;
    st0 = strobes;
    fd0 = fdones;
    for (int by = 0; by < OUT_H; by++) begin
      for (int bx = 0; bx < OUT_W; bx++) begin
        pix = 16'(bx * 7 + by * 131) ^ 16'hA5C3;
        q.push_back(mk(pix, by * OUT_W + bx, (bx == OUT_W - 1) && (by == OUT_H - 1)));
        px(1, bx * 4, by * 4, pix);
      end
    end
    idle(3);
    chk("frame_strobes", 32'(strobes - st0), 19200);
    chk("frame_done_cnt", 32'(fdones - fd0), 1);
    chk("frame_last_addr", 32'(Addr_o), 19199);
    chk("queue_drained", 32'(q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
